// File: rtl/out_writeback_if.sv
// Source-stream and BRAM write-port bundle for the output write-back stage.
interface out_writeback_if #(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned VEC     = 4,
    parameter int unsigned DWIDTH  = 8,
    parameter int unsigned AWIDTH  = 10
) ();
    localparam int unsigned VW = VEC * DWIDTH;

    logic [NUM_SRC*VW-1:0] src_data;
    logic [NUM_SRC-1:0]    src_valid;
    logic                  bram_grant;
    logic [AWIDTH-1:0]     bram_addr;
    logic [VW-1:0]         bram_wdata;
    logic [VEC-1:0]        bram_we;
    logic                  bram_en;

    // Producer side: result streams and the BRAM arbiter
    modport master (
        output src_data, src_valid, bram_grant,
        input  bram_addr, bram_wdata, bram_we, bram_en
    );

    // Write-back stage side
    modport slave (
        input  src_data, src_valid, bram_grant,
        output bram_addr, bram_wdata, bram_we, bram_en
    );
endinterface

// File: rtl/out_writeback.sv
// Output write-back stage: selects one result stream, buffers vectors in a
// small FIFO and writes them to BRAM C at strided addresses.
module out_writeback #(
    parameter int unsigned DWIDTH     = 8,
    parameter int unsigned VEC        = 4,
    parameter int unsigned AWIDTH     = 10,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH-1:0] addr_stride,
    input  logic [CNT_W-1:0]  num_rows,
    input  logic [SEL_W-1:0]  src_sel,
    out_writeback_if.slave    bus,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [CNT_W-1:0]  rows_written
);
    localparam int unsigned VW    = VEC * DWIDTH;
    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state, state_n;
    logic [AWIDTH-1:0]  stride_l;
    logic [AWIDTH-1:0]  next_addr;
    logic [CNT_W-1:0]   num_l;
    logic [SEL_W-1:0]   sel_l;
    logic [CNT_W-1:0]   acc_cnt;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [VW-1:0]      mem [FIFO_DEPTH];

    logic               sel_valid_c;
    logic [VW-1:0]      sel_data_c;
    logic               fifo_empty_c, fifo_full_c;
    logic               load_c, take_c, push_c, drop_c, pop_c;

    // Route the latched source onto a single valid/data pair
    always_comb begin
        sel_valid_c = 1'b0;
        sel_data_c  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (sel_l == SEL_W'(i)) begin
                sel_valid_c = bus.src_valid[i];
                sel_data_c  = bus.src_data[i*VW +: VW];
            end
        end
    end

    // FIFO status and per-cycle transfer decisions
    always_comb begin
        fifo_empty_c = (wr_ptr == rd_ptr);
        fifo_full_c  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                       (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
        load_c       = (state == S_IDLE) && start;
        pop_c        = !fifo_empty_c && bus.bram_grant;
        take_c       = (state == S_RUN) && sel_valid_c && (acc_cnt != num_l);
        push_c       = take_c && (!fifo_full_c || pop_c);
        drop_c       = take_c && fifo_full_c && !pop_c;
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = (num_rows == '0) ? S_DONE : S_RUN;
            S_RUN:   if (acc_cnt == num_l) state_n = S_DRAIN;
            S_DRAIN: if (fifo_empty_c && ((rows_written == num_l) || (acc_cnt == num_l)))
                         state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Status flags registered from the upcoming state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= (state_n == S_RUN) || (state_n == S_DRAIN);
            done <= (state_n == S_DONE);
        end
    end

    // Transfer configuration captured on an accepted start
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stride_l <= '0;
            num_l    <= '0;
            sel_l    <= '0;
        end else if (load_c) begin
            stride_l <= addr_stride;
            num_l    <= num_rows;
            sel_l    <= src_sel;
        end
    end

    // Accepted/written counters, address walker and sticky overflow
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_cnt      <= '0;
            rows_written <= '0;
            next_addr    <= '0;
            overflow     <= 1'b0;
        end else if (load_c) begin
            acc_cnt      <= '0;
            rows_written <= '0;
            next_addr    <= base_addr;
            overflow     <= 1'b0;
        end else begin
            if (take_c) acc_cnt <= acc_cnt + CNT_W'(1);
            if (pop_c) begin
                rows_written <= rows_written + CNT_W'(1);
                next_addr    <= next_addr + stride_l;
            end
            if (drop_c) overflow <= 1'b1;
        end
    end

    // FIFO pointers; the extra MSB separates full from empty
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // FIFO storage; a push into the slot being popped reads the old entry
    always_ff @(posedge clk) begin
        if (push_c) mem[wr_ptr[IDX_W-1:0]] <= sel_data_c;
    end

    // Registered BRAM write port; address holds on idle cycles
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.bram_addr  <= '0;
            bus.bram_wdata <= '0;
            bus.bram_we    <= '0;
            bus.bram_en    <= 1'b0;
        end else if (pop_c) begin
            bus.bram_addr  <= next_addr;
            bus.bram_wdata <= mem[rd_ptr[IDX_W-1:0]];
            bus.bram_we    <= '1;
            bus.bram_en    <= 1'b1;
        end else begin
            bus.bram_wdata <= '0;
            bus.bram_we    <= '0;
            bus.bram_en    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_out_writeback.sv
// Self-checking bench for out_writeback: queue-based reference model compared
// every cycle, plus literal expectations for each directed scenario.
module tb_out_writeback;
    localparam int unsigned DW = 8, VEC = 4, AW = 10, NS = 4, SW = 2, DEPTH = 4, CW = 16;
    localparam int unsigned VW = VEC * DW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic [AW-1:0] base_addr, addr_stride;
    logic [CW-1:0] num_rows;
    logic [SW-1:0] src_sel;
    logic          busy, done, overflow;
    logic [CW-1:0] rows_written;

    out_writeback_if #(.NUM_SRC(NS), .VEC(VEC), .DWIDTH(DW), .AWIDTH(AW)) bus ();

    out_writeback #(.DWIDTH(DW), .VEC(VEC), .AWIDTH(AW), .NUM_SRC(NS), .SEL_W(SW),
                    .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .start(start), .base_addr(base_addr),
        .addr_stride(addr_stride), .num_rows(num_rows), .src_sel(src_sel),
        .bus(bus), .busy(busy), .done(done), .overflow(overflow),
        .rows_written(rows_written)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mkword(input int s, input int n);
        return {8'(s), 8'(n), 8'hC3, 8'(s ^ n)};
    endfunction

    // Reference model: phase 0 idle, 1 accepting, 2 draining, 3 done
    int            m_phase, m_nph, m_acc, m_rows, m_sel;
    logic [AW-1:0] m_base, m_stride;
    logic [CW-1:0] m_num;
    logic [VW-1:0] m_q[$];
    bit            m_full, m_take, m_pop;
    logic [VW-1:0] m_v;
    logic [AW-1:0] e_addr;
    logic [VW-1:0] e_wdata;
    logic [VEC-1:0] e_we;
    logic          e_en, e_busy, e_done, e_ovf;
    logic [CW-1:0] e_rows;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_phase = 0; m_acc = 0; m_rows = 0; m_sel = 0;
            m_base = '0; m_stride = '0; m_num = '0; m_q.delete();
            e_addr = '0; e_wdata = '0; e_we = '0; e_en = 0;
            e_busy = 0; e_done = 0; e_ovf = 0; e_rows = '0;
        end else begin
            m_nph = m_phase;
            case (m_phase)
                0: if (start) begin
                       m_base = base_addr; m_stride = addr_stride; m_num = num_rows;
                       m_sel = int'(src_sel); m_acc = 0; m_rows = 0; e_ovf = 0;
                       m_nph = (num_rows == 0) ? 3 : 1;
                   end
                1: if (m_acc == int'(m_num)) m_nph = 2;
                2: if (m_q.size() == 0) m_nph = 3;
                default: m_nph = 0;
            endcase
            m_full = (m_q.size() == DEPTH);
            m_take = (m_phase == 1) && bus.src_valid[m_sel] && (m_acc != int'(m_num));
            m_v    = bus.src_data[m_sel*VW +: VW];
            m_pop  = (m_q.size() > 0) && bus.bram_grant;
            if (m_pop) begin
                e_wdata = m_q.pop_front();
                e_addr  = AW'(int'(m_base) + m_rows * int'(m_stride));
                e_we    = '1;
                e_en    = 1;
                m_rows++;
            end else begin
                e_wdata = '0; e_we = '0; e_en = 0;
            end
            if (m_take) begin
                m_acc++;
                if (m_full && !m_pop) e_ovf = 1;
                else m_q.push_back(m_v);
            end
            m_phase = m_nph;
            e_busy  = (m_nph == 1) || (m_nph == 2);
            e_done  = (m_nph == 3);
            e_rows  = CW'(m_rows);
        end
    end

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("bram_en",      bus.bram_en,    e_en);
            chk("bram_we",      bus.bram_we,    e_we);
            chk("bram_wdata",   bus.bram_wdata, e_wdata);
            chk("bram_addr",    bus.bram_addr,  e_addr);
            chk("busy",         busy,           e_busy);
            chk("done",         done,           e_done);
            chk("overflow",     overflow,       e_ovf);
            chk("rows_written", rows_written,   e_rows);
        end
    end

    // Write and done-pulse log for literal checks
    logic [AW-1:0] log_addr[$];
    logic [VW-1:0] log_data[$];
    int            done_cnt = 0;
    always @(negedge clk) begin
        if (resetn && bus.bram_en) begin
            log_addr.push_back(bus.bram_addr);
            log_data.push_back(bus.bram_wdata);
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] s,
                               input logic [CW-1:0] n, input logic [SW-1:0] sel);
        base_addr = b; addr_stride = s; num_rows = n; src_sel = sel; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [NS-1:0] mask, input int n);
        bus.src_valid = mask;
        for (int s = 0; s < int'(NS); s++) bus.src_data[s*VW +: VW] = mkword(s, n);
        tick();
        bus.src_valid = '0;
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk({name, "_done_timeout"}, 64'(seen), 64'd1);
        tick();
        tick();
    endtask

    task automatic chk_wr(input string name, input int i, input logic [AW-1:0] a,
                          input logic [VW-1:0] d);
        if (i < log_addr.size()) begin
            chk($sformatf("%s_wr%0d_addr", name, i), log_addr[i], a);
            chk($sformatf("%s_wr%0d_data", name, i), log_data[i], d);
        end else begin
            chk($sformatf("%s_wr%0d_missing", name, i), 64'(log_addr.size()), 64'(i + 1));
        end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; base_addr = '0; addr_stride = '0;
        num_rows = '0; src_sel = '0;
        bus.src_valid = '0; bus.src_data = '0; bus.bram_grant = 1'b0;
        repeat (3) tick();
        chk("rst_en",   bus.bram_en, 1'b0);
        chk("rst_addr", bus.bram_addr, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rows", rows_written, '0);
        resetn = 1'b1;
        chk_on = 1'b1;
        tick();

        // 1: three rows from source 1, stride 4
        clear_log();
        bus.bram_grant = 1'b1;
        pulse_start(10'h010, 10'd4, 16'd3, 2'd1);
        feed(4'b0010, 0);
        chk("t1_no_early_write", bus.bram_en, 1'b0);
        feed(4'b0010, 1);
        chk("t1_lat_en",   bus.bram_en, 1'b1);
        chk("t1_lat_addr", bus.bram_addr, 10'h010);
        feed(4'b0010, 2);
        wait_done("t1", 20);
        chk("t1_nwr", 64'(log_addr.size()), 64'd3);
        chk_wr("t1", 0, 10'h010, 32'h0100C301);
        chk_wr("t1", 1, 10'h014, 32'h0101C300);
        chk_wr("t1", 2, 10'h018, 32'h0102C303);
        chk("t1_done_cnt", 64'(done_cnt), 64'd1);
        chk("t1_rows", rows_written, 16'd3);
        chk("t1_ovf", overflow, 1'b0);

        // 2: unselected sources ignored
        clear_log();
        pulse_start(10'h100, 10'd1, 16'd2, 2'd2);
        for (int i = 0; i < 10; i++) feed(4'b1001, i);
        feed(4'b0100, 20);
        feed(4'b0100, 21);
        wait_done("t2", 20);
        chk("t2_nwr", 64'(log_addr.size()), 64'd2);
        chk_wr("t2", 0, 10'h100, 32'h0214C316);
        chk_wr("t2", 1, 10'h101, 32'h0215C317);
        chk("t2_ovf", overflow, 1'b0);

        // 3: FIFO overflow while grant is withheld
        clear_log();
        bus.bram_grant = 1'b0;
        pulse_start(10'h020, 10'd2, 16'd6, 2'd0);
        for (int i = 0; i < 6; i++) feed(4'b0001, i);
        tick();
        chk("t3_ovf_set", overflow, 1'b1);
        chk("t3_rows_pre", rows_written, 16'd0);
        bus.bram_grant = 1'b1;
        wait_done("t3", 40);
        chk("t3_nwr", 64'(log_addr.size()), 64'd4);
        chk_wr("t3", 0, 10'h020, 32'h0000C300);
        chk_wr("t3", 1, 10'h022, 32'h0001C301);
        chk_wr("t3", 2, 10'h024, 32'h0002C302);
        chk_wr("t3", 3, 10'h026, 32'h0003C303);
        chk("t3_rows", rows_written, 16'd4);
        chk("t3_ovf", overflow, 1'b1);

        // 4: address wrap at the top of the BRAM
        clear_log();
        pulse_start(10'h3FE, 10'd1, 16'd4, 2'd3);
        for (int i = 0; i < 4; i++) feed(4'b1000, i);
        wait_done("t4", 20);
        chk_wr("t4", 0, 10'h3FE, 32'h0300C303);
        chk_wr("t4", 1, 10'h3FF, 32'h0301C302);
        chk_wr("t4", 2, 10'h000, 32'h0302C301);
        chk_wr("t4", 3, 10'h001, 32'h0303C300);

        // 5: zero-row transfer
        clear_log();
        pulse_start(10'h050, 10'd1, 16'd0, 2'd0);
        chk("t5_done", done, 1'b1);
        chk("t5_busy", busy, 1'b0);
        for (int i = 0; i < 3; i++) feed(4'b1111, i);
        chk("t5_nwr", 64'(log_addr.size()), 64'd0);
        chk("t5_done_cnt", 64'(done_cnt), 64'd1);

        // 6: reset mid-transfer, then a clean single-row transfer
        clear_log();
        pulse_start(10'h200, 10'd1, 16'd5, 2'd1);
        feed(4'b0010, 0);
        feed(4'b0010, 1);
        tick();
        chk("t6_rows_pre", rows_written, 16'd2);
        resetn = 1'b0;
        #1;
        chk("t6_rst_en",   bus.bram_en, 1'b0);
        chk("t6_rst_addr", bus.bram_addr, '0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_rows", rows_written, '0);
        repeat (2) tick();
        resetn = 1'b1;
        repeat (4) tick();
        chk("t6_no_done", 64'(done_cnt), 64'd0);
        clear_log();
        pulse_start(10'h040, 10'd1, 16'd1, 2'd1);
        feed(4'b0010, 9);
        wait_done("t6", 20);
        chk("t6_nwr", 64'(log_addr.size()), 64'd1);
        chk_wr("t6", 0, 10'h040, 32'h0109C308);
        chk("t6_ovf", overflow, 1'b0);
        chk("t6_rows", rows_written, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/out_writeback.md
Name: out_writeback

Overview:
- Parametrised output write-back stage between the post-processing blocks (matmul, norm, activation, pool) and output BRAM C.
- Selects one of NUM_SRC result streams and buffers accepted vectors in a small FIFO.
- Generates strided BRAM addresses from a programmable base and writes when the BRAM port is granted.
- Signals completion after a programmed number of rows, and flags dropped data.

Parameters:
- DWIDTH, 8, bits per element
- VEC, 4, elements per BRAM word
- AWIDTH, 10, BRAM address width
- NUM_SRC, 4, number of selectable source streams
- SEL_W, 2, width of src_sel (clog2 of NUM_SRC, minimum 1)
- FIFO_DEPTH, 4, buffered vectors (power of 2, at least 2)
- CNT_W, 16, width of row counters

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that latches the configuration and begins a transfer
- base_addr  in  AWIDTH  address of the first row
- addr_stride  in  AWIDTH  address increment per written row
- num_rows  in  CNT_W  number of vectors to write
- src_sel  in  SEL_W  source stream index
- src_data  in  NUM_SRC*VEC*DWIDTH  concatenated source vectors; source i occupies bits [i*VEC*DWIDTH +: VEC*DWIDTH]
- src_valid  in  NUM_SRC  per-source data-available strobe
- bram_grant  in  1  BRAM port available this cycle
- bram_addr  out  AWIDTH  write address
- bram_wdata  out  VEC*DWIDTH  write data
- bram_we  out  VEC  byte-lane write enable
- bram_en  out  1  port enable
- busy  out  1  transfer in progress
- done  out  1  one-cycle completion pulse
- overflow  out  1  sticky flag: a selected valid was dropped because the FIFO was full
- rows_written  out  CNT_W  rows written in the current or last transfer

Behaviour:
- Reset (resetn low, asynchronous):
  - State IDLE; FIFO empty; all counters 0.
  - Outputs: bram_addr=0, bram_wdata=0, bram_we=0, bram_en=0, busy=0, done=0, overflow=0, rows_written=0.
  - Reset mid-transfer abandons the transfer; no done pulse follows.
- States:
  - IDLE -> RUN on start. Latches base_addr, addr_stride, num_rows and src_sel; clears overflow, rows_written and the accepted count. The FIFO is already empty in IDLE.
  - IDLE -> DONE when start arrives with num_rows=0. No writes occur.
  - RUN -> DRAIN when accepted count == latched num_rows.
  - DRAIN -> DONE when FIFO empty and rows_written == num_rows.
  - DONE -> IDLE after one cycle. done=1 only while in DONE.
  - busy=1 in RUN and DRAIN.
- start while busy is ignored; the latched configuration is unchanged.
- Accept (RUN only):
  - Push when src_valid[src_sel_latched]=1 and the FIFO is not full, or is full with a pop in the same cycle.
  - A push when full without a pop drops the data and sets overflow; the accepted count still increments, so the transfer length is preserved.
  - Valids on unselected sources are ignored and never set overflow.
  - Valids in IDLE, DRAIN or DONE are ignored.
  - src_sel changes after start have no effect.
- Write:
  - Each cycle with FIFO non-empty and bram_grant=1, pop one entry.
  - Next cycle, registered outputs present bram_wdata=entry, bram_we=all ones, bram_en=1, bram_addr = base + k*addr_stride, where k = rows_written before the pop.
  - rows_written increments on the pop.
  - Cycles with no pop: bram_we=0, bram_en=0, bram_wdata=0, bram_addr holds.
  - Minimum latency is 2 clocks from an accepted valid to the registered write (1 cycle FIFO write, then 1 cycle output register); back-to-back throughput is 1 row/cycle.
  - Dropped vectors are never written; rows_written counts written rows only.
  - In the overflow case, DONE is reached when FIFO empty and accepted count == num_rows, even though rows_written < num_rows.
- Address arithmetic is an adder of AWIDTH bits and wraps modulo 2^AWIDTH.
- A stride of 0 rewrites the same address every row.
- The FIFO is a circular buffer with wrap-around pointers; full and empty are distinguished by an extra pointer bit.

Test Plan:
1. base=0x010, stride=4, num_rows=3, src_sel=1, src_valid[1] high 3 consecutive cycles, grant=1 -> writes at 0x010, 0x014, 0x018 with the matching data; first write 2 cycles after the first valid; done pulse once; rows_written=3; overflow=0.
2. src_sel=2, valids only on sources 0 and 3 for 10 cycles, then 2 valids on source 2 with num_rows=2 -> only the source-2 vectors are written; overflow=0.
3. FIFO_DEPTH=4, grant=0 while 6 selected valids arrive with num_rows=6, then grant=1 -> the first 4 are written in order; overflow=1; rows_written=4; done asserted after the FIFO drains.
4. base=0x3FE, stride=1, num_rows=4, AWIDTH=10 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
5. num_rows=0 start -> done the cycle after start; bram_we never asserted; busy stays 0.
6. resetn low while 2 of 5 rows are written -> outputs 0 immediately and no done pulse; then a new start with num_rows=1 completes normally with overflow cleared.
